// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the 7-segment scan reader.
//   - Active-low segment patterns SEG_0..SEG_9 and SEG_BLANK, ordered {a,b,c,d,e,f,g}.
//   - BCD_INVALID: the value a digit holds when it has no legal capture.
//   - state_e: the reader FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0001100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] BCD_INVALID = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        LOCKED
    } state_e;

endpackage

// File: rtl/seg7_scan_reader_if.sv
// seg7_scan_reader_if: groups the scanned display bus and the readback outputs.
//   an, seg         : active-low anode and segment lines sampled from the display pins
//   clear_i         : clears the sticky bad-pattern flags
//   digits_o        : captured BCD, digit i at [4i+3:4i]
//   valid_o         : per-digit legal-capture flag
//   bad_pattern_o   : per-digit sticky undecodable-pattern flag
//   update_o        : one-cycle pulse on each capture
//   frame_o         : one-cycle pulse once every digit has been captured
// Optional (macro SEG7_SCAN_READER_DP_EN): seg_dp (active-low decimal point in), dp_o.
// master modport drives the display side, slave modport is the reader.
interface seg7_scan_reader_if #(
    parameter int NUM_DIGITS = 4
);
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    clear_i;
    logic [4*NUM_DIGITS-1:0] digits_o;
    logic [NUM_DIGITS-1:0]   valid_o;
    logic [NUM_DIGITS-1:0]   bad_pattern_o;
    logic                    update_o;
    logic                    frame_o;
`ifdef SEG7_SCAN_READER_DP_EN
    logic                    seg_dp;
    logic [NUM_DIGITS-1:0]   dp_o;

    modport master (
        output an, seg, seg_dp, clear_i,
        input  digits_o, valid_o, bad_pattern_o, update_o, frame_o, dp_o
    );
    modport slave (
        input  an, seg, seg_dp, clear_i,
        output digits_o, valid_o, bad_pattern_o, update_o, frame_o, dp_o
    );
`else
    modport master (
        output an, seg, clear_i,
        input  digits_o, valid_o, bad_pattern_o, update_o, frame_o
    );
    modport slave (
        input  an, seg, clear_i,
        output digits_o, valid_o, bad_pattern_o, update_o, frame_o
    );
`endif
endinterface

// File: rtl/seg7_encoder.sv
// seg7_encoder: combinational inverse of the BCD-to-segment decoder.
//   seg_i   : active-low segment pattern {a,b,c,d,e,f,g}
//   bcd_o   : decoded digit, BCD_INVALID for unknown patterns
//   legal_o : 1 when seg_i is one of the ten digit patterns
module seg7_encoder
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] bcd_o,
    output logic       legal_o
);

    always_comb begin
        bcd_o   = BCD_INVALID;
        legal_o = 1'b1;
        case (seg_i)
            SEG_0:   bcd_o = 4'd0;
            SEG_1:   bcd_o = 4'd1;
            SEG_2:   bcd_o = 4'd2;
            SEG_3:   bcd_o = 4'd3;
            SEG_4:   bcd_o = 4'd4;
            SEG_5:   bcd_o = 4'd5;
            SEG_6:   bcd_o = 4'd6;
            SEG_7:   bcd_o = 4'd7;
            SEG_8:   bcd_o = 4'd8;
            SEG_9:   bcd_o = 4'd9;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: monitors a multiplexed 7-segment bus and reads back the
// digit shown at each anode position.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : seg7_scan_reader_if.slave (display inputs, readback outputs)
// Optional feature macro SEG7_SCAN_READER_DP_EN adds decimal-point capture.
//
// state  | meaning
// IDLE   | anode blank or multiple lows, nothing to track
// SETTLE | legal anode, counting identical consecutive samples
// LOCKED | current sample captured, waiting for a change
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input logic                clk,
    input logic                rst_n,
    seg7_scan_reader_if.slave  bus
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
`ifdef SEG7_SCAN_READER_DP_EN
    localparam int SW = NUM_DIGITS + 8;
`else
    localparam int SW = NUM_DIGITS + 7;
`endif

    logic [SW-1:0]           smp_q, prev_q, smp_raw;
    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d, bad_q, bad_d, seen_q, seen_d;
    logic                    update_q, frame_q;
    logic                    capture, legal_cur, same, enc_legal;
    logic [NUM_DIGITS-1:0]   an_cur, an_prev, sel;
    logic [IW-1:0]           idx_prev;
    logic [3:0]              enc_bcd;
    int                      zeros;

`ifdef SEG7_SCAN_READER_DP_EN
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    assign smp_raw = {bus.an, bus.seg, bus.seg_dp};
`else
    assign smp_raw = {bus.an, bus.seg};
`endif

    assign an_cur  = smp_q[SW-1 -: NUM_DIGITS];
    assign an_prev = prev_q[SW-1 -: NUM_DIGITS];
    assign same    = (smp_q == prev_q);

    // Capture always uses the previous sample: it is the one the counter has
    // proven stable, whereas the current sample may already be changing.
    seg7_encoder u_enc (
        .seg_i   (prev_q[SW-NUM_DIGITS-1 -: 7]),
        .bcd_o   (enc_bcd),
        .legal_o (enc_legal)
    );

    always_comb begin
        zeros    = 0;
        idx_prev = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_cur[i]) zeros = zeros + 1;
            if (!an_prev[i]) idx_prev = IW'(i);
        end
        legal_cur = (zeros == 1);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (legal_cur) begin
                    state_d = SETTLE;
                    cnt_d   = CW'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == CW'(STABLE_CYCLES)) begin
                    capture = 1'b1;
                    // A change on the capture cycle must restart settling,
                    // otherwise LOCKED would never notice it.
                    if (!legal_cur) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (same) begin
                        state_d = LOCKED;
                    end else begin
                        cnt_d = CW'(1);
                    end
                end else if (!legal_cur) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (same) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = CW'(1);
                end
            end
            LOCKED: begin
                if (!legal_cur) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!same) begin
                    state_d = SETTLE;
                    cnt_d   = CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        digits_d = digits_q;
        valid_d  = valid_q;
        bad_d    = clear_q_or_bad(bus.clear_i, bad_q);
        seen_d   = seen_q;
        sel      = '0;
`ifdef SEG7_SCAN_READER_DP_EN
        dp_d     = dp_q;
`endif
        if (capture) begin
            sel[idx_prev] = 1'b1;
            if (enc_legal) begin
                digits_d[4*int'(idx_prev) +: 4] = enc_bcd;
                valid_d[idx_prev]               = 1'b1;
            end else begin
                digits_d[4*int'(idx_prev) +: 4] = BCD_INVALID;
                valid_d[idx_prev]               = 1'b0;
                bad_d[idx_prev]                 = 1'b1;
            end
`ifdef SEG7_SCAN_READER_DP_EN
            dp_d[idx_prev] = ~prev_q[0];
`endif
            seen_d = ((seen_q | sel) == {NUM_DIGITS{1'b1}}) ? '0 : (seen_q | sel);
        end
    end

    function automatic logic [NUM_DIGITS-1:0] clear_q_or_bad(input logic clr,
                                                             input logic [NUM_DIGITS-1:0] b);
        return clr ? '0 : b;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_q    <= '1;
            prev_q   <= '1;
            state_q  <= IDLE;
            cnt_q    <= '0;
            digits_q <= {NUM_DIGITS{BCD_INVALID}};
            valid_q  <= '0;
            bad_q    <= '0;
            seen_q   <= '0;
            update_q <= 1'b0;
            frame_q  <= 1'b0;
`ifdef SEG7_SCAN_READER_DP_EN
            dp_q     <= '0;
`endif
        end else begin
            smp_q    <= smp_raw;
            prev_q   <= smp_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            bad_q    <= bad_d;
            seen_q   <= seen_d;
            update_q <= capture;
            frame_q  <= capture && ((seen_q | sel) == {NUM_DIGITS{1'b1}});
`ifdef SEG7_SCAN_READER_DP_EN
            dp_q     <= dp_d;
`endif
        end
    end

    assign bus.digits_o      = digits_q;
    assign bus.valid_o       = valid_q;
    assign bus.bad_pattern_o = bad_q;
    assign bus.update_o      = update_q;
    assign bus.frame_o       = frame_q;
`ifdef SEG7_SCAN_READER_DP_EN
    assign bus.dp_o          = dp_q;
`endif

endmodule

// File: tb/tb_seg7_scan_reader.sv
module tb_seg7_scan_reader;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   un, ua, fn, fa;
    int   tot_upd;

    seg7_scan_reader_if #(.NUM_DIGITS(4)) bus ();

    seg7_scan_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Apply a pattern right after an edge (cycle 0) and watch n following edges.
    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n,
                         output int upd_n, output int upd_at,
                         output int frm_n, output int frm_at);
        bus.an  = a;
        bus.seg = s;
        upd_n = 0; upd_at = -1; frm_n = 0; frm_at = -1;
        for (int k = 1; k <= n; k++) begin
            step(1);
            if (bus.update_o) begin
                upd_n++;
                if (upd_at < 0) upd_at = k;
            end
            if (bus.frame_o) begin
                frm_n++;
                if (frm_at < 0) frm_at = k;
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.an      = 4'b1111;
        bus.seg     = 7'b1111111;
        bus.clear_i = 1'b0;
`ifdef SEG7_SCAN_READER_DP_EN
        bus.seg_dp  = 1'b1;
`endif
        #23;
        chk("reset_digits", 32'(bus.digits_o), 32'hFFFF);
        chk("reset_valid", 32'(bus.valid_o), 32'h0);
        chk("reset_bad", 32'(bus.bad_pattern_o), 32'h0);
        chk("reset_update", 32'(bus.update_o), 32'h0);
        chk("reset_frame", 32'(bus.frame_o), 32'h0);
        rst_n = 1'b1;
        step(1);

        // Static scan: digit 0 shows 2
        drive(4'b1110, 7'b0010010, 10, un, ua, fn, fa);
        chk("static_upd_n", 32'(un), 32'd1);
        chk("static_upd_at", 32'(ua), 32'd6);
        chk("static_frame_n", 32'(fn), 32'd0);
        chk("static_digits", 32'(bus.digits_o), 32'hFFF2);
        chk("static_valid", 32'(bus.valid_o), 32'h1);

        // Full frame 1,2,3,4
        tot_upd = 0;
        drive(4'b1110, 7'b1001111, 8, un, ua, fn, fa);
        tot_upd += un;
        chk("frame_d0_frm", 32'(fn), 32'd0);
        drive(4'b1101, 7'b0010010, 8, un, ua, fn, fa);
        tot_upd += un;
        chk("frame_d1_frm", 32'(fn), 32'd0);
        drive(4'b1011, 7'b0000110, 8, un, ua, fn, fa);
        tot_upd += un;
        chk("frame_d2_frm", 32'(fn), 32'd0);
        drive(4'b0111, 7'b1001100, 8, un, ua, fn, fa);
        tot_upd += un;
        chk("frame_d3_frm_n", 32'(fn), 32'd1);
        chk("frame_d3_upd_at", 32'(ua), 32'd6);
        chk("frame_d3_frm_at", 32'(fa), 32'd6);
        chk("frame_upd_total", 32'(tot_upd), 32'd4);
        chk("frame_digits", 32'(bus.digits_o), 32'h4321);
        chk("frame_valid", 32'(bus.valid_o), 32'hF);

        // Glitch: 5 for 2 cycles, then 6
        drive(4'b1101, 7'b0100100, 2, un, ua, fn, fa);
        chk("glitch_no_upd", 32'(un), 32'd0);
        drive(4'b1101, 7'b0100000, 8, un, ua, fn, fa);
        chk("glitch_upd_n", 32'(un), 32'd1);
        chk("glitch_upd_at", 32'(ua), 32'd6);
        chk("glitch_digits", 32'(bus.digits_o), 32'h4361);

        // Bad pattern on digit 2
        drive(4'b1011, 7'b1111110, 8, un, ua, fn, fa);
        chk("bad_upd_n", 32'(un), 32'd1);
        chk("bad_digits", 32'(bus.digits_o), 32'h4F61);
        chk("bad_valid", 32'(bus.valid_o), 32'hB);
        chk("bad_flag", 32'(bus.bad_pattern_o), 32'h4);

        // clear alone
        bus.clear_i = 1'b1;
        step(1);
        bus.clear_i = 1'b0;
        chk("clear_alone", 32'(bus.bad_pattern_o), 32'h0);

        // clear coincident with a new bad capture (capture edge is the 6th)
        bus.an  = 4'b1011;
        bus.seg = 7'b1111100;
        step(5);
        chk("clr_set_pre_upd", 32'(bus.update_o), 32'h0);
        bus.clear_i = 1'b1;
        step(1);
        bus.clear_i = 1'b0;
        chk("clr_set_upd", 32'(bus.update_o), 32'h1);
        chk("clr_set_bad", 32'(bus.bad_pattern_o), 32'h4);
        step(2);

        // Blanking and multiple anodes
        drive(4'b1111, 7'b0000000, 20, un, ua, fn, fa);
        chk("blank_no_upd", 32'(un), 32'd0);
        drive(4'b1100, 7'b0000000, 20, un, ua, fn, fa);
        chk("multi_no_upd", 32'(un), 32'd0);
        chk("illegal_digits", 32'(bus.digits_o), 32'h4F61);
        chk("illegal_valid", 32'(bus.valid_o), 32'hB);
        chk("illegal_bad", 32'(bus.bad_pattern_o), 32'h4);

        // Async reset mid-SETTLE
        bus.an  = 4'b1110;
        bus.seg = 7'b0001111;
        step(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_digits", 32'(bus.digits_o), 32'hFFFF);
        chk("arst_valid", 32'(bus.valid_o), 32'h0);
        chk("arst_bad", 32'(bus.bad_pattern_o), 32'h0);
        bus.an  = 4'b1111;
        bus.seg = 7'b1111111;
        step(2);
        rst_n = 1'b1;
        step(1);
        drive(4'b1110, 7'b0001111, 10, un, ua, fn, fa);
        chk("replay_upd_n", 32'(un), 32'd1);
        chk("replay_upd_at", 32'(ua), 32'd6);
        chk("replay_frame_n", 32'(fn), 32'd0);
        chk("replay_digits", 32'(bus.digits_o), 32'hFFF7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Display-side monitor for the clock's multiplexed 7-segment bus: samples the active-low anode and segment lines and decodes segment patterns back to BCD.
- Holds one captured digit per display position.
- Used for self-check and readback of what the display is actually showing (HH:MM by default).
- It is the inverse of the BCD-to-segment decoder and sits in parallel with the display pins.

Parameters:
- NUM_DIGITS, 4, number of scanned digit positions (anode lines).
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is accepted (must be ≥ 2).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- an  input  NUM_DIGITS  anode enables, active-low, one-hot-low when a digit is driven
- seg  input  7  segment lines, active-low; seg[6]=a … seg[0]=g
- clear_i  input  1  clears all bad_pattern_o flags
- digits_o  output  4*NUM_DIGITS  captured BCD; digit i at [4i+3:4i]
- valid_o  output  NUM_DIGITS  digit i holds a legal decoded value
- bad_pattern_o  output  NUM_DIGITS  sticky: digit i has shown an undecodable pattern
- update_o  output  1  one-cycle pulse on every accepted capture
- frame_o  output  1  one-cycle pulse when every digit has been captured since the last frame_o

Behaviour:
- Reset:
  - digits_o = 4'hF for every digit; valid_o, bad_pattern_o, update_o, frame_o = 0.
  - Seen-mask cleared; FSM in IDLE; stability counter = 0.
- Input register:
  - an and seg are registered once; all comparisons use the registered copy.
  - Sources are same-clock-domain, so no synchronizer is needed.
- Legal anode: exactly one bit of registered an is 0. All-ones (blanking) or multiple lows are illegal.
- FSM states:
  - IDLE: anode illegal. Go to SETTLE when anode is legal; counter = 1.
  - SETTLE:
    - Each cycle, if {an,seg} equals the previous sample, counter increments; otherwise counter = 1.
    - When counter reaches STABLE_CYCLES, perform a capture and go to LOCKED.
    - If the anode becomes illegal, go to IDLE.
  - LOCKED:
    - Stay while {an,seg} is unchanged; no further captures.
    - On any change, go to SETTLE with counter = 1 (or to IDLE if the anode is illegal).
- Capture:
  - Capture occurs on the cycle the count condition is met.
  - Registered outputs update the next cycle, together with update_o = 1 for exactly one cycle.
  - Latency from the first stable sample at the pins to update_o is STABLE_CYCLES + 2 clocks.
- Decode table (seg → BCD):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4
  - 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0001100→9
- Legal capture: digit = decoded value, valid = 1, seen-mask bit set.
- Illegal pattern capture: digit = 4'hF, valid = 0, bad_pattern bit set, seen-mask bit set. update_o still pulses.
- frame_o:
  - Pulses in the same cycle as the update_o that completes the seen-mask.
  - The mask clears in that cycle; that capture's own bit is not retained.
- clear_i:
  - Clears all bad_pattern_o bits.
  - If a bad capture occurs in the same cycle, that digit's bit stays set (set wins).
- Reset mid-operation: returns immediately to reset values; partial counts are discarded.
- Counter width is $clog2(STABLE_CYCLES+1); it saturates and never wraps.

Optional Feature:
- Macro: SEG7_SCAN_READER_DP_EN
- Defined:
  - Adds input seg_dp (1 bit, active-low) and output dp_o (NUM_DIGITS bits, active-high, reset 0).
  - seg_dp is registered and included in the stability comparison.
  - Captured into dp_o[i] on every capture of digit i, including bad captures.
- Undefined: the port and output do not exist; the decimal point is ignored.

Decomposition:
- Package seg7_pkg holds:
  - segment pattern constants SEG_0..SEG_9 and SEG_BLANK (7'b1111111);
  - BCD_INVALID (4'hF);
  - the FSM state enum {IDLE, SETTLE, LOCKED}.
- Sub-module seg7_encoder: combinational seg[6:0] → {bcd[3:0], legal}, using the package constants.
- One-hot anode-to-index conversion stays inline in the top module.

Test Plan:
- Static scan:
  - Stimulus: hold an=4'b1110, seg=7'b0010010 for 10 cycles.
  - Response: exactly one update_o at cycle STABLE_CYCLES+2 (6); digits_o[3:0]=2; valid_o[0]=1.
- Full frame:
  - Stimulus: rotate an through 1110,1101,1011,0111 with patterns 1,2,3,4, each held 8 cycles.
  - Response: digits_o=16'h4321; four update_o pulses; frame_o coincides with the 4th.
- Glitch rejection:
  - Stimulus: digit 1 shows 5 for 2 cycles, then 6 for 8 cycles.
  - Response: single capture of 6; a 5 never appears.
- Bad pattern + clear:
  - Stimulus: digit 2 shows 7'b1111110.
  - Response: digits_o[11:8]=F, valid_o[2]=0, bad_pattern_o[2]=1.
  - Then clear_i pulses alone: the bit clears. clear_i pulsed in the same cycle as a new bad capture: the bit stays 1.
- Blanking/illegal anode:
  - Stimulus: an=1111 or 1100 for 20 cycles.
  - Response: no update_o; outputs unchanged.
- Async reset:
  - Stimulus: assert rst_n low mid-SETTLE, then release and replay the same scan.
  - Response: outputs return to reset values immediately; capture timing restarts from zero.
